// File: rtl/lector_contadores_if.sv
// Signal bundle between lector_contadores and its environment: sweep control,
// the counter-block request/response pair, and the captured results.
interface lector_contadores_if;
    logic       start;
    logic [3:0] state;
    logic       valid_in;
    logic [4:0] data_in;
    logic       req;
    logic [1:0] idx;
    logic [4:0] count_0;
    logic [4:0] count_1;
    logic [4:0] count_2;
    logic [4:0] count_3;
    logic [6:0] total;
    logic       busy;
    logic       done;
    logic       timeout_err;

    modport master (
        input  start, state, valid_in, data_in,
        output req, idx, count_0, count_1, count_2, count_3,
               total, busy, done, timeout_err
    );

    modport slave (
        output start, state, valid_in, data_in,
        input  req, idx, count_0, count_1, count_2, count_3,
               total, busy, done, timeout_err
    );
endinterface

// File: rtl/lector_contadores.sv
// Sweeps the four per-FIFO word counters, captures each 5-bit count and
// reports all four plus their sum, with a per-index timeout on the reply.
module lector_contadores #(
    parameter int         TIMEOUT    = 8,
    parameter logic [3:0] IDLE_CODE  = 4'b0100,
    parameter logic [3:0] RESET_CODE = 4'b0001
) (
    input  logic clk,
    input  logic reset,
    lector_contadores_if.master bus
);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} fsm_t;

    fsm_t          fsm;
    logic [WW-1:0] wait_cnt;
    logic [4:0]    cnt [4];
    logic [6:0]    total;
    logic [6:0]    sum_next;
    logic          req;
    logic [1:0]    idx;
    logic          terr;
    logic          wait_over;

    // Index 3 is captured on the same edge that loads total, so its term
    // comes straight from data_in when the counter block answers.
    always_comb begin
        sum_next = {2'b00, cnt[0]} + {2'b00, cnt[1]} + {2'b00, cnt[2]}
                 + {2'b00, (bus.valid_in ? bus.data_in : cnt[3])};
    end

    assign wait_over = (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= S_IDLE;
            req      <= 1'b0;
            idx      <= 2'd0;
            cnt      <= '{default: 5'd0};
            total    <= 7'd0;
            terr     <= 1'b0;
            wait_cnt <= '0;
        end else if (fsm != S_IDLE && bus.state == RESET_CODE) begin
            fsm   <= S_IDLE;
            req   <= 1'b0;
            cnt   <= '{default: 5'd0};
            total <= 7'd0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt   <= '{default: 5'd0};
                        total <= 7'd0;
                        terr  <= 1'b0;
                        idx   <= 2'd0;
                        req   <= (bus.state == IDLE_CODE);
                        fsm   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // req is a one-cycle pulse; while the main FSM is elsewhere we just keep asking.
                    if (req) begin
                        req      <= 1'b0;
                        wait_cnt <= '0;
                        fsm      <= S_WAIT;
                    end else begin
                        req <= (bus.state == IDLE_CODE);
                    end
                end
                S_WAIT: begin
                    if (bus.valid_in || wait_over) begin
                        if (bus.valid_in) begin
                            cnt[idx] <= bus.data_in;
                        end else begin
                            terr <= 1'b1;
                        end
                        if (idx == 2'd3) begin
                            total <= sum_next;
                            fsm   <= S_DONE;
                        end else begin
                            idx <= idx + 2'd1;
                            req <= (bus.state == IDLE_CODE);
                            fsm <= S_REQ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    fsm <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req         = req;
    assign bus.idx         = idx;
    assign bus.count_0     = cnt[0];
    assign bus.count_1     = cnt[1];
    assign bus.count_2     = cnt[2];
    assign bus.count_3     = cnt[3];
    assign bus.total       = total;
    assign bus.busy        = (fsm != S_IDLE);
    assign bus.done        = (fsm == S_DONE);
    assign bus.timeout_err = terr;
endmodule

// File: tb/tb_lector_contadores.sv
// Scoreboard bench for lector_contadores: a behavioural counter block answers
// requests, sweeps are predicted from the read rules and checked on done.
module tb_lector_contadores;
    localparam int         TIMEOUT    = 8;
    localparam logic [3:0] IDLE_CODE  = 4'b0100;
    localparam logic [3:0] RESET_CODE = 4'b0001;

    typedef struct {
        logic [3:0][4:0] cnt;
        logic [6:0]      total;
        logic            terr;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    lector_contadores_if bus ();

    lector_contadores #(
        .TIMEOUT    (TIMEOUT),
        .IDLE_CODE  (IDLE_CODE),
        .RESET_CODE (RESET_CODE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [4:0] resp_val [4];
    logic [3:0] resp_mask = 4'hF;
    bit         spur = 1'b0;
    bit         pend = 1'b0;
    logic [1:0] pend_idx = 2'd0;

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(bus.count_0);
            1:       return int'(bus.count_1);
            2:       return int'(bus.count_2);
            default: return int'(bus.count_3);
        endcase
    endfunction

    function automatic logic [3:0] other_code();
        logic [3:0] c;
        do c = 4'($urandom); while (c == IDLE_CODE || c == RESET_CODE);
        return c;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Counter block: answers a sampled req one cycle later, unless its index is muted.
    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = 5'd0;
        forever begin
            @(posedge clk);
            #1;
            if (spur) begin
                bus.valid_in = 1'b1;
                bus.data_in  = 5'd9;
            end else if (pend) begin
                bus.valid_in = 1'b1;
                bus.data_in  = resp_val[pend_idx];
            end else begin
                bus.valid_in = 1'b0;
                bus.data_in  = 5'($urandom);
            end
            pend     = bus.req && resp_mask[bus.idx];
            pend_idx = bus.idx;
        end
    end

    // Monitor: pops the prediction on every done and checks protocol rules each cycle.
    initial begin
        exp_t e;
        bit prev_req    = 1'b0;
        bit expect_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (expect_idle) begin
                check_output("busy_after_done", int'(bus.busy), 0);
                check_output("done_one_cycle", int'(bus.done), 0);
                expect_idle = 1'b0;
            end
            if (bus.req) check_output("req_back_to_back", int'(prev_req), 0);
            if (bus.done && !expect_idle) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < 4; i++)
                        check_output($sformatf("count_%0d", i), get_cnt(i), int'(e.cnt[i]));
                    check_output("total", int'(bus.total), int'(e.total));
                    check_output("timeout_err", int'(bus.timeout_err), int'(e.terr));
                    check_output("done_cycle", cyc, e.cyc);
                    expect_idle = 1'b1;
                end
            end
            prev_req = bus.req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep: predict the result from the read rules, drive it, wait for the monitor.
    task automatic apply_stimulus(input logic [3:0][4:0] vals, input logic [3:0] mask,
                                  input int stall);
        exp_t e;
        int   span = stall;
        int   budget = 0;
        e.total = 7'd0;
        e.terr  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.cnt[i] = mask[i] ? vals[i] : 5'd0;
            e.total  = e.total + 7'(e.cnt[i]);
            if (!mask[i]) e.terr = 1'b1;
            span += 1 + (mask[i] ? 1 : TIMEOUT);
            resp_val[i] = vals[i];
        end
        e.cyc = cyc + 1 + span;
        resp_mask = mask;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.state = (stall > 0) ? other_code() : IDLE_CODE;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < stall; k++) begin
            check_output("req_during_stall", int'(bus.req), 0);
            check_output("busy_during_stall", int'(bus.busy), 1);
            if (k < stall - 1) tick();
        end
        bus.state = IDLE_CODE;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            check_output("done_never_came", 0, 1);
            sb.delete();
        end
        tick();
    endtask

    initial begin
        logic [3:0][4:0] v;
        bus.start = 1'b0;
        bus.state = IDLE_CODE;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) resp_val[i] = 5'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_output("reset_busy", int'(bus.busy), 0);
        check_output("reset_total", int'(bus.total), 0);
        check_output("reset_count_0", int'(bus.count_0), 0);
        check_output("reset_terr", int'(bus.timeout_err), 0);

        $display("[TB] nominal sweep 3/0/17/31");
        v = {5'd31, 5'd17, 5'd0, 5'd3};
        apply_stimulus(v, 4'hF, 0);

        $display("[TB] index 2 never answered");
        v = {5'd12, 5'd7, 5'd22, 5'd5};
        apply_stimulus(v, 4'b1011, 0);

        $display("[TB] main FSM elsewhere for 5 cycles");
        v = {5'd1, 5'd2, 5'd30, 5'd14};
        apply_stimulus(v, 4'hF, 5);

        $display("[TB] abort via RESET_CODE in cycle 4");
        resp_mask = 4'hF;
        for (int i = 0; i < 4; i++) resp_val[i] = 5'd21;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.state = RESET_CODE;
        tick();
        check_output("abort_busy", int'(bus.busy), 0);
        check_output("abort_count_0", int'(bus.count_0), 0);
        check_output("abort_total", int'(bus.total), 0);
        check_output("abort_terr", int'(bus.timeout_err), 0);
        bus.state = IDLE_CODE;
        repeat (12) tick();

        $display("[TB] reset mid-sweep with an ignored start");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_output("ignored_start_idx", int'(bus.idx), 1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("midreset_busy", int'(bus.busy), 0);
        check_output("midreset_count_0", int'(bus.count_0), 0);
        check_output("midreset_idx", int'(bus.idx), 0);
        check_output("midreset_req", int'(bus.req), 0);
        check_output("midreset_total", int'(bus.total), 0);
        repeat (3) tick();

        $display("[TB] spurious valid_in while idle");
        spur = 1'b1;
        repeat (3) tick();
        spur = 1'b0;
        check_output("spur_count_0", int'(bus.count_0), 0);
        check_output("spur_count_3", int'(bus.count_3), 0);
        check_output("spur_busy", int'(bus.busy), 0);
        v = {5'd4, 5'd8, 5'd16, 5'd2};
        apply_stimulus(v, 4'hF, 0);

        $display("[TB] randomized sweeps");
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 4; i++) v[i] = 5'($urandom);
            apply_stimulus(v, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                           int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] simulation time limit exceeded");
    end
endmodule

// File: doc/lector_contadores.md
# lector_contadores

Downstream reader for the per-FIFO word counters of the PCIe transaction layer. On a `start` pulse it sweeps counter index 0..3, issuing a one-cycle `req` with the matching `idx` to the counter block. It captures each returned 5-bit count on `valid_in` and presents all four counts plus their sum with a one-cycle `done`. A per-index timeout guards against a missing `valid_in`, so a stalled counter cannot hang the sweep.

## Interface
- `TIMEOUT`, 8: max cycles spent waiting for `valid_in` per index (≥2).
- `IDLE_CODE`, 4'b0100: main-FSM state code in which the counter block answers requests.
- `RESET_CODE`, 4'b0001: main-FSM state code that clears the counter block.

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in S_IDLE.
- `state` in 4: current main-FSM state code.
- `valid_in` in 1: counter-block read strobe.
- `data_in` in 5: counter value, qualified by `valid_in`.
- `req` out 1: read request to the counter block.
- `idx` out 2: counter index being requested.
- `count_0`..`count_3` out 5 each: captured counts.
- `total` out 7: count_0+count_1+count_2+count_3, zero-extended (max 124).
- `busy` out 1: high in any state except S_IDLE.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `timeout_err` out 1: sticky; set by any index timeout; cleared only by `reset` or a new accepted `start`.

## Operation
- Registered FSM states: S_IDLE, S_REQ, S_WAIT, S_DONE. All outputs are registered or decoded from the state register only, never from `valid_in` combinationally.
- Reset (`reset`=1 at a posedge) forces S_IDLE and all outputs to 0, including `count_*`, `total`, `idx`, and `timeout_err`. This applies from any state, mid-sweep included.
- S_IDLE, with `start`=1: clear `count_*`, `total`, `timeout_err`; set `idx`=0; go to S_REQ. `start` received in any other state is ignored.
- S_REQ: `req` = 1 only when `state`==IDLE_CODE. If `state`≠IDLE_CODE, `req` stays 0 and the FSM holds in S_REQ indefinitely with no timeout. Leave for S_WAIT on the cycle after `req` was driven high, clearing the wait counter.
- S_WAIT: `req`=0.
  - `valid_in`=1: store `data_in` into `count_[idx]`.
  - No `valid_in` after TIMEOUT cycles in S_WAIT: `count_[idx]` stays 0 and `timeout_err` is set.
  - Either event: if `idx`==3 go to S_DONE, else `idx`+1 and go to S_REQ.
- S_DONE: `total` is loaded with the 4-way sum; `done`=1 for exactly this cycle; next state is S_IDLE. `count_*`, `total`, and `idx`=3 hold until the next accepted `start`.
- Abort: `state`==RESET_CODE while `busy` returns to S_IDLE next cycle. It clears `count_*` and `total`, gives no `done`, and leaves `timeout_err` unchanged.
- `valid_in` outside S_WAIT is ignored and does not change stored counts.
- The sum uses a 7-bit adder with no overflow possible; inputs are zero-extended.

## Timing
- Counter block returns `valid_in` one cycle after it samples `req`.
- Nominal sweep (`state`==IDLE_CODE throughout, `start` sampled at edge 0):
  - `req`/`idx`=0 in cycle 1; `valid_in` in cycle 2.
  - idx1 in cycles 3/4, idx2 in cycles 5/6, idx3 in cycles 7/8.
  - `done` and final `total` visible in cycle 9; `busy` low in cycle 10.
- `req` is never high for two consecutive cycles. `idx` is stable for the whole S_REQ/S_WAIT pair of each index.
- Worst case per index with `state` at IDLE_CODE: 1 + TIMEOUT cycles.
- Back-to-back: `start` is accepted again in the cycle after `done` (S_IDLE).

## Test plan
- Reset, then a sweep with responder counts 3, 0, 17, 31 → `done` in cycle 9; `count_*` = 3/0/17/31; `total`=51; `timeout_err`=0.
- Responder never answers idx 2 (TIMEOUT=8) → idx 2 spends 8 cycles in S_WAIT; `count_2`=0; `timeout_err`=1; sweep completes with `done` in cycle 16.
- `state` = 4'b0010 for 5 cycles after `start`, then IDLE_CODE → `req` stays low for those 5 cycles with no timeout; sweep then finishes normally.
- `state`=RESET_CODE in cycle 4 → S_IDLE next cycle; `count_*`=0; no `done` pulse.
- `reset` in cycle 6, plus `start` pulsed in cycle 3 while busy → the cycle-3 `start` is ignored; after `reset` all outputs are 0 and `busy`=0.
- Spurious `valid_in` with `data_in`=9 while in S_IDLE, then a normal sweep → the 9 is never captured; counts come only from the sweep.
